// File: rtl/ysyx_041514_if_req_pkg.sv
// Shared constants and state encoding for the instruction-fetch request stage.
// Holds the reset PC, the canonical NOP and the IFREQ state enum.
package ysyx_041514_if_req_pkg;

    localparam logic [63:0] ysyx_041514_PC_START = 64'h0000_0000_8000_0000;
    localparam logic [63:0] ysyx_041514_INST_NOP = 64'h0000_0000_0000_0013;

    typedef enum logic [2:0] {
        ysyx_041514_IFREQ_IDLE = 3'd0,
        ysyx_041514_IFREQ_REQ  = 3'd1,
        ysyx_041514_IFREQ_WAIT = 3'd2,
        ysyx_041514_IFREQ_HOLD = 3'd3,
        ysyx_041514_IFREQ_KILL = 3'd4
    } ifreq_state_e;

endpackage

// File: rtl/ysyx_041514_next_pc.sv
// Next-fetch-PC priority mux: redirect beats BPU prediction beats sequential PC+4.
module ysyx_041514_next_pc #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_bpu_valid,
    input  logic [XLEN-1:0] i_bpu_pc,
    output logic [XLEN-1:0] o_next_pc
);

    logic [XLEN-1:0] w_seq_pc;

    // Wraps modulo 2^XLEN by construction.
    assign w_seq_pc = i_pc + XLEN'(4);

    always_comb begin
        if (i_redirect_valid) begin
            o_next_pc = i_redirect_pc;
        end else if (i_bpu_valid) begin
            o_next_pc = i_bpu_pc;
        end else begin
            o_next_pc = w_seq_pc;
        end
    end

endmodule

// File: rtl/ysyx_041514_if_req.sv
// Instruction-fetch request stage: owns the fetch PC, drives icache requests, presents data.
// Optional misaligned-target trapping via YSYX_041514_IF_MISALIGN_CHECK_EN.
module ysyx_041514_if_req
    import ysyx_041514_if_req_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(ysyx_041514_PC_START)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic [XLEN-1:0] bpu_pc_i,
    input  logic            bpu_pc_valid_i,
    output logic            icache_req_valid_o,
    output logic [XLEN-1:0] icache_req_addr_o,
    input  logic            icache_req_ready_i,
    input  logic            icache_resp_valid_i,
    input  logic [XLEN-1:0] icache_resp_data_i,
`ifdef YSYX_041514_IF_MISALIGN_CHECK_EN
    output logic            if_misalign_o,
`endif
    output logic [XLEN-1:0] inst_addr_o,
    output logic            if_rdata_valid_o,
    output logic [XLEN-1:0] if_rdata_o
);

    ifreq_state_e    r_state;
    ifreq_state_e    w_state_nxt;
    ifreq_state_e    w_redir_dest;
    ifreq_state_e    w_kill_dest;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_data;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_rvalid;
    logic            w_accept;
    logic            w_tgt_misalign;
    logic            w_pending_nop;

`ifdef YSYX_041514_IF_MISALIGN_CHECK_EN
    logic            r_misalign;

    assign w_redirect_pc  = redirect_pc_i;
    assign w_tgt_misalign = (redirect_pc_i[1:0] != 2'b00);
    assign w_pending_nop  = r_misalign;
    assign if_misalign_o  = w_rvalid && (r_state == ysyx_041514_IFREQ_HOLD) && r_misalign;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid_i) begin
            r_misalign <= w_tgt_misalign;
        end else if (w_accept) begin
            r_misalign <= 1'b0;
        end
    end
`else
    // Without the check, targets are silently word-aligned.
    assign w_redirect_pc  = {redirect_pc_i[XLEN-1:2], redirect_pc_i[1:0] & 2'b00};
    assign w_tgt_misalign = 1'b0;
    assign w_pending_nop  = 1'b0;
`endif

    assign w_accept     = w_rvalid && !stall_i;
    assign w_redir_dest = w_tgt_misalign ? ysyx_041514_IFREQ_HOLD : ysyx_041514_IFREQ_REQ;
    assign w_kill_dest  = w_pending_nop ? ysyx_041514_IFREQ_HOLD : ysyx_041514_IFREQ_REQ;

    ysyx_041514_next_pc #(
        .XLEN(XLEN)
    ) u_next_pc (
        .i_pc            (r_pc),
        .i_redirect_valid(redirect_valid_i),
        .i_redirect_pc   (w_redirect_pc),
        .i_bpu_valid     (bpu_pc_valid_i),
        .i_bpu_pc        (bpu_pc_i),
        .o_next_pc       (w_next_pc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ysyx_041514_IFREQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: w_state_nxt defaults to r_state so no path through this block infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid_i) begin
            unique case (r_state)
                ysyx_041514_IFREQ_WAIT: w_state_nxt = icache_resp_valid_i ? w_redir_dest
                                                                          : ysyx_041514_IFREQ_KILL;
                ysyx_041514_IFREQ_KILL: w_state_nxt = ysyx_041514_IFREQ_KILL;
                default:                w_state_nxt = w_redir_dest;
            endcase
        end else begin
            unique case (r_state)
                ysyx_041514_IFREQ_IDLE: w_state_nxt = ysyx_041514_IFREQ_REQ;
                ysyx_041514_IFREQ_REQ: begin
                    if (icache_req_ready_i) w_state_nxt = ysyx_041514_IFREQ_WAIT;
                end
                ysyx_041514_IFREQ_WAIT: begin
                    if (icache_resp_valid_i) begin
                        w_state_nxt = w_accept ? ysyx_041514_IFREQ_REQ : ysyx_041514_IFREQ_HOLD;
                    end
                end
                ysyx_041514_IFREQ_HOLD: begin
                    if (w_accept) w_state_nxt = ysyx_041514_IFREQ_REQ;
                end
                ysyx_041514_IFREQ_KILL: begin
                    if (icache_resp_valid_i) w_state_nxt = w_kill_dest;
                end
                default: w_state_nxt = ysyx_041514_IFREQ_IDLE;
            endcase
        end
    end

    // Redirect suppresses valid in the same cycle; data is zeroed whenever not valid.
    always_comb begin
        icache_req_valid_o = (r_state == ysyx_041514_IFREQ_REQ);
        w_rvalid           = 1'b0;
        if_rdata_o         = '0;
        if (!redirect_valid_i) begin
            if ((r_state == ysyx_041514_IFREQ_WAIT) && icache_resp_valid_i) begin
                w_rvalid   = 1'b1;
                if_rdata_o = icache_resp_data_i;
            end else if (r_state == ysyx_041514_IFREQ_HOLD) begin
                w_rvalid   = 1'b1;
                if_rdata_o = w_pending_nop ? XLEN'(ysyx_041514_INST_NOP) : r_data;
            end
        end
    end

    assign if_rdata_valid_o  = w_rvalid;
    assign icache_req_addr_o = r_pc;
    assign inst_addr_o       = r_pc;

    // NOTE: the capture register is reset so if_rdata_o never exposes X, not for correctness.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc   <= PC_RESET;
            r_data <= '0;
        end else begin
            if (redirect_valid_i || w_accept) begin
                r_pc <= w_next_pc;
            end
            if ((r_state == ysyx_041514_IFREQ_WAIT) && icache_resp_valid_i && !redirect_valid_i) begin
                r_data <= icache_resp_data_i;
            end
        end
    end

endmodule
